// File: rtl/cti_commit_ctrl.sv
// -----------------------------------------------------------------------------
// cti_commit_ctrl
//
// Controller for the CTI commit queue. The queue is a circular buffer of
// control-transfer-instruction records. It lives in a commit RAM with several
// write ports and one read port. This block does not hold the record data. It
// only drives the RAM addresses, the write enables and the lane-steering
// selects, and it tracks occupancy.
//
// Each cycle the committing lanes (ctiCommit_i) are compacted onto write
// ports 0..p-1, so that their records land in consecutive slots starting at
// tail. A commit group is written whole or not at all. If it does not fit, it
// is dropped and the sticky overflow flag is set. One record per cycle drains
// from head to the branch-predictor update interface.
//
// Handshake (update interface): updValid_o is high whenever the queue is
// non-empty, and the head record is present on the RAM read data in that
// cycle. The record transfers on a cycle where updValid_o && updReady_i. Until
// that happens, head and the record it points at hold steady. updValid_o does
// not depend on updReady_i.
//
// Parameters
//   COMMIT_WIDTH  commit lanes / RAM write ports (1..4)
//   DEPTH         queue entries, power of two, >= 2*COMMIT_WIDTH
//   INDEX         log2(DEPTH)
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset
//   ctiCommit_i   per-lane "this lane retires a CTI" bits
//   wrAddr_o      per-port RAM write address
//   wrEn_o        per-port RAM write enable
//   wrLane_o      per-port commit-lane select for the write datapath
//   rdAddr_o      RAM read address (= head)
//   updValid_o    head record available
//   updReady_i    update consumer accepts the head record
//   ctiFull_o     registered: fewer than COMMIT_WIDTH free entries
//   count_o       registered occupancy
//   overflow_o    sticky: a commit group was dropped for lack of space
//
// Optional feature, enabled by defining CTI_PERF_CNT_EN:
//   drainCnt_o    saturating count of records drained
//   fullCycles_o  saturating count of cycles with ctiFull_o high
// -----------------------------------------------------------------------------
module cti_commit_ctrl #(
   parameter int COMMIT_WIDTH = 4,
   parameter int DEPTH        = 16,
   parameter int INDEX        = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [COMMIT_WIDTH-1:0]               ctiCommit_i,
   output logic [COMMIT_WIDTH-1:0][INDEX-1:0]    wrAddr_o,
   output logic [COMMIT_WIDTH-1:0]               wrEn_o,
   output logic [COMMIT_WIDTH-1:0][1:0]          wrLane_o,
   output logic [INDEX-1:0]                      rdAddr_o,
   output logic                                  updValid_o,
   input  logic                                  updReady_i,
   output logic                                  ctiFull_o,
   output logic [INDEX:0]                        count_o,
   output logic                                  overflow_o
`ifdef CTI_PERF_CNT_EN
   ,
   output logic [31:0]                           drainCnt_o,
   output logic [31:0]                           fullCycles_o
`endif
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [INDEX-1:0] head_q;
   logic [INDEX-1:0] tail_q;
   logic [INDEX:0]   count_q;
   logic             full_q;
   logic             overflow_q;

   // ---------------------------------------------------------------------------
   // Compaction: the n-th set commit bit, counted from lane 0, goes to port n.
   // The running slot counter doubles as the popcount of the commit group.
   // ---------------------------------------------------------------------------
   logic [COMMIT_WIDTH-1:0][INDEX-1:0] cmp_addr;
   logic [COMMIT_WIDTH-1:0][1:0]       cmp_lane;
   logic [COMMIT_WIDTH-1:0]            cmp_en;
   logic [2:0]                         slot;

   always_comb begin
      cmp_addr = '0;
      cmp_lane = '0;
      cmp_en   = '0;
      slot     = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         if (ctiCommit_i[k]) begin
            // Unused ports stay zero. The slot address wraps naturally mod DEPTH.
            cmp_addr[slot[1:0]] = tail_q + INDEX'(slot);
            cmp_lane[slot[1:0]] = 2'(k);
            cmp_en[slot[1:0]]   = 1'b1;
            slot                = slot + 3'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Space check. It uses the occupancy at the start of the cycle, and it
   // credits a pop that happens in the same cycle, because the RAM frees the
   // head slot at the same edge that writes the new records.
   // ---------------------------------------------------------------------------
   logic               pop;
   logic [INDEX+1:0]   push_w;
   logic [INDEX+1:0]   room_w;
   logic               accept;
   logic [INDEX:0]     push_acc;
   logic [INDEX:0]     count_n;
   logic [INDEX+1:0]   free_n;
   logic               full_n;

   assign updValid_o = (count_q != '0);
   assign pop        = updValid_o & updReady_i;

   assign push_w = (INDEX+2)'(slot);
   assign room_w = (INDEX+2)'(DEPTH) - {1'b0, count_q}
                 + {{(INDEX+1){1'b0}}, pop};
   assign accept = (push_w <= room_w);

   assign push_acc = accept ? (INDEX+1)'(slot) : '0;
   assign count_n  = count_q + push_acc - {{INDEX{1'b0}}, pop};

   // The full flag is registered. It is computed from the post-edge occupancy,
   // so it describes the cycle after the update.
   assign free_n = (INDEX+2)'(DEPTH) - {1'b0, count_n};
   assign full_n = (free_n < (INDEX+2)'(COMMIT_WIDTH));

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // A rejected group must not touch the RAM at all. Writes are also blocked
   // during reset, so stray commit bits cannot corrupt the RAM.
   assign wrEn_o     = (accept && !reset) ? cmp_en : '0;
   assign wrAddr_o   = cmp_addr;
   assign wrLane_o   = cmp_lane;
   assign rdAddr_o   = head_q;
   assign ctiFull_o  = full_q;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

   // ---------------------------------------------------------------------------
   // Queue state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) begin
            tail_q <= tail_q + INDEX'(slot);
         end else begin
            overflow_q <= 1'b1;
         end
         if (pop) begin
            head_q <= head_q + INDEX'(1);
         end
         count_q <= count_n;
         full_q  <= full_n;
      end
   end

`ifdef CTI_PERF_CNT_EN
   // ---------------------------------------------------------------------------
   // Performance counters. They saturate rather than wrap, so that a long run
   // never reports a small, misleading value.
   // ---------------------------------------------------------------------------
   logic [31:0] drain_cnt_q;
   logic [31:0] full_cyc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         drain_cnt_q <= '0;
         full_cyc_q  <= '0;
      end else begin
         if (pop && (drain_cnt_q != '1)) begin
            drain_cnt_q <= drain_cnt_q + 32'd1;
         end
         if (full_q && (full_cyc_q != '1)) begin
            full_cyc_q <= full_cyc_q + 32'd1;
         end
      end
   end

   assign drainCnt_o   = drain_cnt_q;
   assign fullCycles_o = full_cyc_q;
`endif

endmodule

// File: tb/tb_cti_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cti_commit_ctrl
//
// Self-checking bench for cti_commit_ctrl.
//
// The bench keeps an independent model of head, tail, count, full and
// overflow. Alongside it sits a RAM model. The RAM model is written through
// the DUT's write ports, and its data comes from per-lane record values that
// the bench generates.
//
// When a commit group is accepted, its records are queued in lane order as the
// expected drain order. Each pop reads the RAM model at rdAddr_o and compares
// the value with the front of that queue.
// -----------------------------------------------------------------------------
module tb_cti_commit_ctrl;

   localparam int CW    = 4;
   localparam int DEPTH = 16;
   localparam int INDEX = 4;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic                         clk;
   logic                         reset;
   logic [CW-1:0]                ctiCommit_i;
   logic [CW-1:0][INDEX-1:0]     wrAddr_o;
   logic [CW-1:0]                wrEn_o;
   logic [CW-1:0][1:0]           wrLane_o;
   logic [INDEX-1:0]             rdAddr_o;
   logic                         updValid_o;
   logic                         updReady_i;
   logic                         ctiFull_o;
   logic [INDEX:0]               count_o;
   logic                         overflow_o;
`ifdef CTI_PERF_CNT_EN
   logic [31:0]                  drainCnt_o;
   logic [31:0]                  fullCycles_o;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cti_commit_ctrl #(
      .COMMIT_WIDTH (CW),
      .DEPTH        (DEPTH),
      .INDEX        (INDEX)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ctiCommit_i  (ctiCommit_i),
      .wrAddr_o     (wrAddr_o),
      .wrEn_o       (wrEn_o),
      .wrLane_o     (wrLane_o),
      .rdAddr_o     (rdAddr_o),
      .updValid_o   (updValid_o),
      .updReady_i   (updReady_i),
      .ctiFull_o    (ctiFull_o),
      .count_o      (count_o),
      .overflow_o   (overflow_o)
`ifdef CTI_PERF_CNT_EN
      ,
      .drainCnt_o   (drainCnt_o),
      .fullCycles_o (fullCycles_o)
`endif
   );

   // ---------------------------------------------------------------------------
   // Reference model and scoreboard
   // ---------------------------------------------------------------------------
   int          checks;
   int          failures;
   int          m_head;
   int          m_tail;
   int          m_count;
   logic        m_full;
   logic        m_ovf;
   int          m_drain;
   int          m_fullc;
   logic [15:0] ram [DEPTH];
   logic [15:0] lane_data [CW];
   logic [15:0] exp_q[$];

   task automatic model_reset();
      m_head  = 0;
      m_tail  = 0;
      m_count = 0;
      m_full  = 1'b0;
      m_ovf   = 1'b0;
      m_drain = 0;
      m_fullc = 0;
      exp_q.delete();
   endtask

   // ---------------------------------------------------------------------------
   // Driver: hold reset across one edge while commit bits are asserted
   // ---------------------------------------------------------------------------
   task automatic do_reset(input logic [CW-1:0] commit);
      @(negedge clk);
      reset       = 1'b1;
      ctiCommit_i = commit;
      updReady_i  = 1'b1;
      #1;
      checks++;
      if (wrEn_o !== '0) begin
         failures++;
         $display("FAIL reset_wren: got %b expected %b", wrEn_o, {CW{1'b0}});
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (wrEn_o !== '0) begin
         failures++;
         $display("FAIL reset_wren_hold: got %b expected %b", wrEn_o, {CW{1'b0}});
      end
      reset       = 1'b0;
      ctiCommit_i = '0;
      updReady_i  = 1'b0;
      model_reset();
   endtask

   // ---------------------------------------------------------------------------
   // Driver + checker for one cycle. It applies commit/ready, checks the
   // combinational and registered outputs against the model, runs the
   // scoreboard, and then advances the model across the clock edge.
   // ---------------------------------------------------------------------------
   task automatic step(input logic [CW-1:0] commit, input logic ready);
      int              p;
      logic            m_pop;
      logic            acc;
      logic [CW-1:0]   e_en;
      logic [INDEX-1:0] e_addr [CW];
      logic [1:0]      e_lane [CW];
      logic [15:0]     got;
      logic [15:0]     exp_v;

      @(negedge clk);
      ctiCommit_i = commit;
      updReady_i  = ready;
      for (int k = 0; k < CW; k++) lane_data[k] = 16'($urandom_range(0, 65535));
      #1;

      p = 0;
      for (int n = 0; n < CW; n++) begin
         e_addr[n] = '0;
         e_lane[n] = '0;
      end
      for (int k = 0; k < CW; k++) begin
         if (commit[k]) begin
            e_addr[p] = INDEX'((m_tail + p) % DEPTH);
            e_lane[p] = 2'(k);
            p++;
         end
      end
      m_pop = (m_count != 0) && ready;
      acc   = (p <= (DEPTH - m_count + (m_pop ? 1 : 0)));
      e_en  = '0;
      if (acc) for (int n = 0; n < p; n++) e_en[n] = 1'b1;

      checks++;
      if (updValid_o !== (m_count != 0)) begin
         failures++;
         $display("FAIL upd_valid: got %b expected %b", updValid_o, (m_count != 0));
      end
      checks++;
      if (rdAddr_o !== INDEX'(m_head)) begin
         failures++;
         $display("FAIL rd_addr: got %0d expected %0d", rdAddr_o, m_head);
      end
      checks++;
      if (count_o !== (INDEX+1)'(m_count)) begin
         failures++;
         $display("FAIL count: got %0d expected %0d", count_o, m_count);
      end
      checks++;
      if (ctiFull_o !== m_full) begin
         failures++;
         $display("FAIL cti_full: got %b expected %b (count %0d)", ctiFull_o, m_full, m_count);
      end
      checks++;
      if (overflow_o !== m_ovf) begin
         failures++;
         $display("FAIL overflow: got %b expected %b", overflow_o, m_ovf);
      end
      checks++;
      if (wrEn_o !== e_en) begin
         failures++;
         $display("FAIL wr_en: got %b expected %b (commit %b count %0d)", wrEn_o, e_en, commit, m_count);
      end
      for (int n = 0; n < CW; n++) begin
         checks++;
         if (wrAddr_o[n] !== e_addr[n]) begin
            failures++;
            $display("FAIL wr_addr[%0d]: got %0d expected %0d (commit %b tail %0d)", n, wrAddr_o[n], e_addr[n], commit, m_tail);
         end
         checks++;
         if (wrLane_o[n] !== e_lane[n]) begin
            failures++;
            $display("FAIL wr_lane[%0d]: got %0d expected %0d (commit %b)", n, wrLane_o[n], e_lane[n], commit);
         end
      end

      // Drain side: the RAM read happens before this cycle's writes land.
      if (m_pop) begin
         got = ram[rdAddr_o];
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL drain_data: got %h expected no record (queue model empty)", got);
         end else begin
            exp_v = exp_q.pop_front();
            if (got !== exp_v) begin
               failures++;
               $display("FAIL drain_data: got %h expected %h", got, exp_v);
            end
         end
      end

      if (acc) begin
         for (int k = 0; k < CW; k++) if (commit[k]) exp_q.push_back(lane_data[k]);
      end

      // The RAM model is written through the DUT's ports. The lane select
      // chooses which lane's record is stored.
      for (int n = 0; n < CW; n++) begin
         if (wrEn_o[n]) ram[wrAddr_o[n]] = lane_data[wrLane_o[n]];
      end

      @(posedge clk);
      m_fullc = m_fullc + (m_full ? 1 : 0);
      m_drain = m_drain + (m_pop ? 1 : 0);
      if (acc) begin
         m_tail  = (m_tail + p) % DEPTH;
         m_count = m_count + p;
      end else begin
         m_ovf = 1'b1;
      end
      if (m_pop) begin
         m_head  = (m_head + 1) % DEPTH;
         m_count = m_count - 1;
      end
      m_full = ((DEPTH - m_count) < CW);
`ifdef CTI_PERF_CNT_EN
      #1;
      checks++;
      if (drainCnt_o !== 32'(m_drain)) begin
         failures++;
         $display("FAIL drain_cnt: got %0d expected %0d", drainCnt_o, m_drain);
      end
      checks++;
      if (fullCycles_o !== 32'(m_fullc)) begin
         failures++;
         $display("FAIL full_cycles: got %0d expected %0d", fullCycles_o, m_fullc);
      end
`endif
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      do_reset(4'b1111);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b1);
   endtask

   task automatic test_compaction();
      do_reset(4'b0000);
      step(4'b1010, 1'b0);   // ports 0/1 -> addr 0/1, lanes 1/3
      step(4'b0000, 1'b0);   // count 2, valid, rdAddr 0
      step(4'b0101, 1'b1);
      step(4'b1001, 1'b1);
      step(4'b1110, 1'b1);
      step(4'b1111, 1'b1);
      for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);
   endtask

   task automatic test_wrap();
      do_reset(4'b0000);
      step(4'b1111, 1'b1);
      step(4'b1111, 1'b1);
      step(4'b1111, 1'b1);
      step(4'b0011, 1'b1);   // tail now 14, queue non-empty
      step(4'b0111, 1'b1);   // addresses 14, 15, 0
      step(4'b0001, 1'b1);   // tail ended at 1
      for (int i = 0; i < 14; i++) step(4'b0000, 1'b1);
   endtask

   task automatic test_full_overflow();
      do_reset(4'b0000);
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b0);
      step(4'b0001, 1'b0);   // count 13
      step(4'b0000, 1'b0);   // full visible
      step(4'b1111, 1'b0);   // dropped whole, overflow sets
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);   // overflow still sticky
      do_reset(4'b0101);     // reset mid-operation discards the entries
      step(4'b0000, 1'b1);
   endtask

   task automatic test_simultaneous();
      do_reset(4'b0000);
      step(4'b1111, 1'b0);
      step(4'b0001, 1'b0);   // count 5
      step(4'b0011, 1'b1);   // push 2, pop 1
      step(4'b0000, 1'b0);   // count 6, head 1
      for (int i = 0; i < 7; i++) step(4'b0000, 1'b1);
   endtask

   task automatic test_stall();
      do_reset(4'b0000);
      step(4'b0111, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_reset(4'b0000);
      // Full-width groups every cycle with a 1-per-cycle drain. This fills the
      // queue and then keeps driving commits so that drops happen at the boundary.
      for (int i = 0; i < 8; i++) step(4'b1111, 1'b1);
      for (int i = 0; i < 18; i++) step(4'b0000, 1'b1);
   endtask

   task automatic test_random();
      logic [CW-1:0] c;
      logic          r;
      do_reset(4'b0000);
      for (int i = 0; i < 300; i++) begin
         c = CW'($urandom_range(0, 15));
         if (m_full && ($urandom_range(0, 3) != 0)) c = '0;
         r = ($urandom_range(0, 3) != 0);
         step(c, r);
      end
      for (int i = 0; i < DEPTH + 2; i++) step(4'b0000, 1'b1);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_complete: got %0d records left expected 0", exp_q.size());
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      ctiCommit_i = '0;
      updReady_i  = 1'b0;
      for (int i = 0; i < DEPTH; i++) ram[i] = '0;
      for (int k = 0; k < CW; k++) lane_data[k] = '0;
      model_reset();

      test_reset();
      test_compaction();
      test_wrap();
      test_full_overflow();
      test_simultaneous();
      test_stall();
      test_back_to_back();
      test_random();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
